// File: rtl/pgb_trace_capture.sv
// pgb_trace_capture: observe-only trace buffer for the pGB core.
// Captures CPU uop, MMU write and end-of-frame events into a circular buffer.
// Capture starts on arm and stops a programmable number of entries after a
// trigger. The buffer is then read out oldest-first through a registered port.
module pgb_trace_capture #(
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W     = 16,
  parameter int CMD_W      = 5
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iCpuValid,
  input  logic [ADDR_W-1:0]      iCpuPc,
  input  logic [CMD_W-1:0]       iCpuCmd,
  input  logic                   iMmuWe,
  input  logic [ADDR_W-1:0]      iMmuAddr,
  input  logic [7:0]             iMmuData,
  input  logic                   iEof,
  input  logic                   iArm,
  input  logic                   iTrigEn,
  input  logic [ADDR_W-1:0]      iTrigPc,
  input  logic                   iForceTrig,
  input  logic [DEPTH_LOG2-1:0]  iPostCount,
  input  logic                   iRdReq,
  output logic [ADDR_W+17:0]     oRdData,
  output logic                   oRdValid,
  output logic                   oRdEmpty,
  output logic [1:0]             oState,
  output logic [7:0]             oDropCnt
);

  localparam int ENTRY_W = 2 + ADDR_W + 16;
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  cnt_t               count_q, count_d;
  cnt_t               unread_q, unread_d;
  ptr_t               post_cnt_q, post_cnt_d;
  ptr_t               post_cfg_q, post_cfg_d;
  logic               hold_v_q, hold_v_d;
  logic [ENTRY_W-1:0] hold_q, hold_d;
  logic [7:0]         drop_q, drop_d;
  logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               we;
  logic [ENTRY_W-1:0] wdata;
  logic [15:0]        cmd_ext;
  logic [ENTRY_W-1:0] cpu_e, mmu_e, eof_e;
  logic [1:0]         lost;
  logic [8:0]         drop_sum;
  logic               capture, trig;

  // Next-state: event arbitration, hold/drop bookkeeping, FSM and read port
  always_comb begin
    cmd_ext               = '0;
    cmd_ext[CMD_W-1:0]    = iCpuCmd;
    cpu_e                 = {2'b01, iCpuPc, cmd_ext};
    mmu_e                 = {2'b10, iMmuAddr, 8'h00, iMmuData};
    eof_e                 = {2'b11, iCpuPc, 16'h0000};

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unread_d   = unread_q;
    post_cnt_d = post_cnt_q;
    post_cfg_d = post_cfg_q;
    hold_v_d   = hold_v_q;
    hold_d     = hold_q;
    drop_d     = drop_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    wdata      = '0;
    lost       = '0;
    drop_sum   = '0;
    trig       = 1'b0;
    capture    = (state_q == S_ARMED) || (state_q == S_POST);

    if (iArm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      unread_d   = '0;
      post_cnt_d = '0;
      post_cfg_d = iPostCount;
      hold_v_d   = 1'b0;
      hold_d     = '0;
      drop_d     = '0;
      rd_data_d  = '0;
    end else if (capture) begin
      // CPU > EOF > held MMU > fresh MMU
      if (iCpuValid) begin
        we    = 1'b1;
        wdata = cpu_e;
      end else if (iEof) begin
        we    = 1'b1;
        wdata = eof_e;
      end else if (hold_v_q) begin
        we       = 1'b1;
        wdata    = hold_q;
        hold_v_d = 1'b0;
      end else if (iMmuWe) begin
        we    = 1'b1;
        wdata = mmu_e;
      end

      if (iEof && iCpuValid) lost = lost + 2'd1;
      // An MMU write that cannot go out now parks in the hold register,
      // unless that register is still occupied at the start of this cycle
      if (iMmuWe && (iCpuValid || iEof || hold_v_q)) begin
        if (hold_v_q) begin
          lost = lost + 2'd1;
        end else begin
          hold_v_d = 1'b1;
          hold_d   = mmu_e;
        end
      end
      drop_sum = {1'b0, drop_q} + {7'd0, lost};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (we) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (count_q != FULL) count_d = count_q + cnt_t'(1);
      end

      if (state_q == S_ARMED) begin
        trig = iForceTrig || (iTrigEn && iCpuValid && (iCpuPc == iTrigPc));
        if (trig) begin
          if (post_cfg_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_POST;
            post_cnt_d = post_cfg_q;
          end
        end
      end else if (we) begin
        post_cnt_d = post_cnt_q - ptr_t'(1);
        if (post_cnt_q == ptr_t'(1)) state_d = S_DONE;
      end

      // Read pointer is set up from the final write so a read can start at once
      if (state_d == S_DONE) begin
        rd_ptr_d = (count_d == FULL) ? wr_ptr_d : '0;
        unread_d = count_d;
      end
    end else if (state_q == S_DONE) begin
      if (iRdReq && (unread_q != '0)) begin
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
        unread_d   = unread_q - cnt_t'(1);
      end
    end
  end

  // Control and status registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unread_q   <= '0;
      post_cnt_q <= '0;
      post_cfg_q <= '0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      drop_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unread_q   <= unread_d;
      post_cnt_q <= post_cnt_d;
      post_cfg_q <= post_cfg_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Trace storage; contents beyond count are never read so no reset is needed
  always_ff @(posedge iClock) begin
    if (we && !iReset) mem[wr_ptr_q] <= wdata;
  end

  assign oRdData  = rd_data_q;
  assign oRdValid = rd_valid_q;
  assign oRdEmpty = (state_q != S_DONE) || (unread_q == '0);
  assign oState   = state_q;
  assign oDropCnt = drop_q;

endmodule

// File: tb/tb_pgb_trace_capture.sv
// Directed bench for pgb_trace_capture (depth 16) with a scoreboard queue.
module tb_pgb_trace_capture;

  localparam int DL = 4;
  localparam int AW = 16;
  localparam int CW = 5;
  localparam int EW = 2 + AW + 16;

  logic          iClock = 1'b0;
  logic          iReset, iCpuValid, iMmuWe, iEof, iArm, iTrigEn, iForceTrig, iRdReq;
  logic [AW-1:0] iCpuPc, iMmuAddr, iTrigPc;
  logic [CW-1:0] iCpuCmd;
  logic [7:0]    iMmuData;
  logic [DL-1:0] iPostCount;
  logic [EW-1:0] oRdData;
  logic          oRdValid, oRdEmpty;
  logic [1:0]    oState;
  logic [7:0]    oDropCnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [EW-1:0] exp_q[$];

  pgb_trace_capture #(.DEPTH_LOG2(DL), .ADDR_W(AW), .CMD_W(CW)) dut (
    .iClock(iClock), .iReset(iReset), .iCpuValid(iCpuValid), .iCpuPc(iCpuPc),
    .iCpuCmd(iCpuCmd), .iMmuWe(iMmuWe), .iMmuAddr(iMmuAddr), .iMmuData(iMmuData),
    .iEof(iEof), .iArm(iArm), .iTrigEn(iTrigEn), .iTrigPc(iTrigPc),
    .iForceTrig(iForceTrig), .iPostCount(iPostCount), .iRdReq(iRdReq),
    .oRdData(oRdData), .oRdValid(oRdValid), .oRdEmpty(oRdEmpty),
    .oState(oState), .oDropCnt(oDropCnt)
  );

  always #5 iClock = ~iClock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [EW-1:0] cpu_ent(input logic [15:0] pc, input logic [4:0] cmd);
    return {2'b01, pc, 11'd0, cmd};
  endfunction

  function automatic logic [EW-1:0] mmu_ent(input logic [15:0] a, input logic [7:0] d);
    return {2'b10, a, 8'h00, d};
  endfunction

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    iCpuValid = 1'b0; iMmuWe = 1'b0; iEof = 1'b0; iArm = 1'b0;
    iForceTrig = 1'b0; iRdReq = 1'b0;
  endtask

  task automatic arm(input logic [DL-1:0] post);
    iArm = 1'b1; iPostCount = post;
    tick();
    iArm = 1'b0;
    check("arm_state", 64'(oState), 64'd1);
    check("arm_drop", 64'(oDropCnt), 64'd0);
  endtask

  task automatic cpu(input logic [15:0] pc, input logic [4:0] cmd);
    iCpuValid = 1'b1; iCpuPc = pc; iCpuCmd = cmd;
    exp_q.push_back(cpu_ent(pc, cmd));
    tick();
    iCpuValid = 1'b0;
  endtask

  task automatic force_trig();
    iForceTrig = 1'b1;
    tick();
    iForceTrig = 1'b0;
    check("trig_state", 64'(oState), 64'd3);
  endtask

  // Back-to-back reads; each accepted request must produce the next queued entry
  task automatic read_n(input int n, input string tag);
    logic [EW-1:0] e;
    iRdReq = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_valid"}, 64'(oRdValid), 64'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check({tag, "_data"}, 64'(oRdData), 64'(e));
    end
    iRdReq = 1'b0;
  endtask

  initial begin
    quiet();
    iReset = 1'b1; iCpuPc = '0; iCpuCmd = '0; iMmuAddr = '0; iMmuData = '0;
    iTrigEn = 1'b0; iTrigPc = '0; iPostCount = '0;
    tick(); tick();
    iReset = 1'b0;
    check("rst_state", 64'(oState), 64'd0);
    check("rst_empty", 64'(oRdEmpty), 64'd1);
    check("rst_valid", 64'(oRdValid), 64'd0);
    check("rst_data", 64'(oRdData), 64'd0);
    check("rst_drop", 64'(oDropCnt), 64'd0);

    // Basic capture, forced trigger, in-order readout
    arm(4'd0);
    cpu(16'h0100, 5'd1); cpu(16'h0101, 5'd1); cpu(16'h0102, 5'd1);
    force_trig();
    check("t1_empty", 64'(oRdEmpty), 64'd0);
    read_n(3, "t1");
    check("t1_empty_end", 64'(oRdEmpty), 64'd1);
    iRdReq = 1'b1; tick(); iRdReq = 1'b0;
    check("t1_rd_when_empty", 64'(oRdValid), 64'd0);
    check("t1_sb_left", 64'(exp_q.size()), 64'd0);

    // Wrap: 21 entries into 16 slots, PC-match trigger on the last
    arm(4'd0);
    iTrigEn = 1'b1; iTrigPc = 16'h0020;
    for (int i = 0; i < 20; i++) cpu(16'(i), 5'd0);
    check("t2_no_early_trig", 64'(oState), 64'd1);
    cpu(16'h0020, 5'd0);
    iTrigEn = 1'b0;
    check("t2_state", 64'(oState), 64'd3);
    while (exp_q.size() > 16) void'(exp_q.pop_front());
    read_n(16, "t2");
    check("t2_empty_end", 64'(oRdEmpty), 64'd1);

    // CPU beats MMU; MMU lands one cycle later from the hold register; EOF entry
    arm(4'd0);
    iMmuWe = 1'b1; iMmuAddr = 16'h8000; iMmuData = 8'hAB;
    cpu(16'h0200, 5'd2);
    iMmuWe = 1'b0;
    exp_q.push_back(mmu_ent(16'h8000, 8'hAB));
    tick();
    iEof = 1'b1; iCpuPc = 16'h0400;
    exp_q.push_back({2'b11, 16'h0400, 16'h0000});
    tick();
    iEof = 1'b0;
    check("t3_drop", 64'(oDropCnt), 64'd0);
    force_trig();
    read_n(3, "t3");

    // Three CPU+MMU cycles: one held, two dropped; then a lost EOF
    arm(4'd0);
    for (int i = 0; i < 3; i++) begin
      iMmuWe = 1'b1; iMmuAddr = 16'(16'h9000 + i); iMmuData = 8'(i + 1);
      cpu(16'(16'h0300 + i), 5'd3);
    end
    iMmuWe = 1'b0;
    check("t4_drop2", 64'(oDropCnt), 64'd2);
    exp_q.push_back(mmu_ent(16'h9000, 8'h01));
    tick();
    iEof = 1'b1;
    cpu(16'h0303, 5'd3);
    iEof = 1'b0;
    check("t4_drop3", 64'(oDropCnt), 64'd3);
    force_trig();
    read_n(2, "t4");
    // Arm during back-to-back reads discards the pending read
    iRdReq = 1'b1; iArm = 1'b1; iPostCount = 4'd0;
    tick();
    iRdReq = 1'b0; iArm = 1'b0;
    check("t6_valid", 64'(oRdValid), 64'd0);
    check("t6_state", 64'(oState), 64'd1);
    check("t6_empty", 64'(oRdEmpty), 64'd1);
    check("t6_drop", 64'(oDropCnt), 64'd0);
    exp_q.delete();

    // Post count 4: trigger entry plus four more, then DONE and ignore
    arm(4'd4);
    iTrigEn = 1'b1; iTrigPc = 16'h0502;
    for (int i = 0; i < 10; i++) begin
      if (i <= 6) cpu(16'(16'h0500 + i), 5'(i));
      else begin
        iCpuValid = 1'b1; iCpuPc = 16'(16'h0500 + i); tick(); iCpuValid = 1'b0;
      end
      check("t5_state", 64'(oState), (i < 2) ? 64'd1 : (i < 6) ? 64'd2 : 64'd3);
    end
    iTrigEn = 1'b0;
    read_n(7, "t5");
    check("t5_empty_end", 64'(oRdEmpty), 64'd1);
    check("t5_sb_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-capture
    arm(4'd0);
    cpu(16'h0600, 5'd1);
    iReset = 1'b1; tick(); iReset = 1'b0;
    check("rst2_state", 64'(oState), 64'd0);
    check("rst2_empty", 64'(oRdEmpty), 64'd1);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pgb_trace_capture.md
Name: pgb_trace_capture

Overview:
- Synthesizable on-chip trace unit for the pGB core; hardware successor of the simulation logging.
- Records DZCPU micro-op flow events, MMU write events and end-of-frame markers into a parametrised circular buffer.
- Supports a PC-match or forced trigger and a programmable post-trigger count; the buffer is read out oldest-first through a registered port.
- Sits beside the DZCPU/MMU inside pGB; observe-only, never stalls the core.

Parameters:
- DEPTH_LOG2, 8, buffer depth = 2**DEPTH_LOG2 entries
- ADDR_W, 16, PC / MMU address width
- CMD_W, 5, uop command width (CMD_W <= 16)
- ENTRY_W, 2+ADDR_W+16, entry width, derived, not overridable

Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous active-high reset
- iCpuValid  in  1  DZCPU flow-enable strobe
- iCpuPc  in  ADDR_W  uop PC
- iCpuCmd  in  CMD_W  uop command
- iMmuWe  in  1  MMU write strobe
- iMmuAddr  in  ADDR_W  MMU write address
- iMmuData  in  8  MMU write data
- iEof  in  1  end-of-flow strobe
- iArm  in  1  pulse: clear buffer, start capture
- iTrigEn  in  1  enable PC-match trigger
- iTrigPc  in  ADDR_W  trigger PC
- iForceTrig  in  1  pulse: immediate trigger
- iPostCount  in  DEPTH_LOG2  entries to capture after trigger, sampled on iArm
- iRdReq  in  1  read next entry
- oRdData  out  ENTRY_W  read entry
- oRdValid  out  1  oRdData valid
- oRdEmpty  out  1  no unread entries
- oState  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- oDropCnt  out  8  saturating count of lost events

Behaviour:
- Reset: state IDLE; wr_ptr, count, rd_ptr, post counter, hold register = 0; oRdData=0, oRdValid=0, oRdEmpty=1, oDropCnt=0.
- Entry format:
  - [ENTRY_W-1:ENTRY_W-2] type: 01 CPU, 10 MMU, 11 EOF.
  - CPU: [ADDR_W+15:16]=PC, [15:0]=zero-extended cmd.
  - MMU: addr field, [7:0]=data, [15:8]=0.
  - EOF: PC field = iCpuPc, low 16 = 0.
- Event priority per cycle: CPU > EOF > MMU. One entry written per cycle.
  - A losing MMU event goes to a 1-deep hold register, written in the first cycle with no higher-priority event.
  - An MMU event arriving while the hold register is occupied increments oDropCnt; the newer event is dropped.
  - A losing EOF event is dropped and increments oDropCnt.
  - oDropCnt saturates at 255.
- Capture occurs only in ARMED and POST. Each written entry lands at wr_ptr on the clock edge after the event; wr_ptr wraps modulo depth; count saturates at depth, and the oldest entry is overwritten.
- FSM:
  - IDLE -> ARMED on iArm.
  - ARMED -> POST on trigger. Trigger = iForceTrig, or (iTrigEn & iCpuValid & iCpuPc==iTrigPc). The triggering CPU event is itself written. The post counter loads the sampled iPostCount.
  - POST: each written entry decrements the post counter. At 0 -> DONE. iPostCount=0 -> DONE in the cycle after the trigger entry is written.
  - DONE: no writes. rd_ptr = (count==depth) ? wr_ptr : 0; unread = count.
  - iArm in any state: restart in ARMED with buffer, pointers, hold register and oDropCnt cleared. Outstanding read output is discarded: oRdValid=0 next cycle.
  - iReset mid-operation: return to reset values.
- Read port:
  - Effective only in DONE with unread != 0.
  - iRdReq -> oRdData/oRdValid=1 on the next cycle; rd_ptr advances with wrap; unread decrements.
  - Back-to-back iRdReq gives one entry per cycle.
  - oRdValid is a 1-cycle pulse per accepted request.
  - iRdReq when empty or not DONE is ignored: oRdValid=0.
- oRdEmpty = (state!=DONE) | (unread==0).
- Reads do not leave DONE; only iArm or iReset does.

Test Plan:
- Reset, iArm, 3 CPU events PC 0x0100/0x0101/0x0102 cmd 1, iForceTrig with iPostCount=0 -> DONE. 3 reads give 0x1_0100_0001 etc. in order; oRdEmpty=1 after the third.
- DEPTH_LOG2=4: 20 CPU events PC 0..19, then trigger at PC 0x20 (iTrigEn) with post 0 -> 16 reads return PCs 5..19 then 0x20; oldest first; wrap correct.
- CPU valid and iMmuWe (addr 0x8000, data 0xAB) in the same cycle, then idle -> CPU entry, then MMU entry 0x2_8000_00AB next; oDropCnt=0.
- Three consecutive cycles of CPU+MMU together -> first MMU held, second and third dropped; oDropCnt=2. Held entry written after CPU events stop.
- iPostCount=4, trigger at cycle T with continuous CPU events -> exactly 5 entries written from T; state DONE at T+5; later events ignored.
- iArm asserted during back-to-back reads in DONE -> oRdValid=0 next cycle, state ARMED, oRdEmpty=1, oDropCnt=0.
